// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single SDRAM controller command port.
// p0 (video readback) has fixed priority, p1/p2 share round-robin, and any port
// that has waited MAX_WAIT cycles is promoted above everything else.
// Only one access is in flight at a time.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WAIT   = 64
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic [2:0]              req,
  input  logic [2:0]              wr,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  input  logic [5:0]              be,
  output logic [2:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ctl_req,
  output logic                    ctl_wr,
  output logic [ADDR_WIDTH-1:0]   ctl_addr,
  output logic [DATA_WIDTH-1:0]   ctl_wdata,
  output logic [1:0]              ctl_be,
  input  logic                    ctl_ack,
  input  logic                    ctl_rvalid,
  input  logic [DATA_WIDTH-1:0]   ctl_rdata,
  output logic                    busy,
  output logic [1:0]              grant_id
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitData, StDone} state_e;

  state_e                  state_q;
  logic                    ctl_req_q, ctl_wr_q, busy_q;
  logic [ADDR_WIDTH-1:0]   ctl_addr_q;
  logic [DATA_WIDTH-1:0]   ctl_wdata_q, rdata_q;
  logic [1:0]              ctl_be_q, grant_q;
  logic [2:0]              ack_q, acked_q;
  logic                    rr_q;  // 0: p1 preferred, 1: p2 preferred
  logic [2:0][CntW-1:0]    wait_q, wait_d;

  logic [2:0] eligible;
  logic       pick_valid;
  logic [1:0] pick_id;
  int         pick_idx;

  // Winner selection for the current IDLE cycle: starvation, then p0, then round-robin.
  always_comb begin
    eligible   = req & ~acked_q;
    pick_valid = 1'b0;
    pick_id    = 2'd0;
    // Descending scan so the lowest-index starved port is the one left standing.
    for (int i = 2; i >= 0; i--) begin
      if (eligible[i] && wait_q[i] == CntMax) begin
        pick_valid = 1'b1;
        pick_id    = 2'(i);
      end
    end
    if (!pick_valid) begin
      if (eligible[0]) begin
        pick_valid = 1'b1;
        pick_id    = 2'd0;
      end else if (eligible[1] && eligible[2]) begin
        pick_valid = 1'b1;
        pick_id    = rr_q ? 2'd2 : 2'd1;
      end else if (eligible[1]) begin
        pick_valid = 1'b1;
        pick_id    = 2'd1;
      end else if (eligible[2]) begin
        pick_valid = 1'b1;
        pick_id    = 2'd2;
      end
    end
    pick_idx = int'(pick_id);
  end

  // Per-port wait counters: count while pending and not owning the port, frozen while owning.
  always_comb begin
    wait_d = wait_q;
    for (int n = 0; n < 3; n++) begin
      if (!req[n]) begin
        wait_d[n] = '0;
      end else if (grant_q == 2'(n) && state_q == StDone) begin
        wait_d[n] = '0;
      end else if (grant_q == 2'(n)) begin
        wait_d[n] = wait_q[n];
      end else if (state_q == StIdle && pick_valid && pick_id == 2'(n)) begin
        wait_d[n] = wait_q[n];
      end else if (wait_q[n] != CntMax) begin
        wait_d[n] = wait_q[n] + cnt_t'(1);
      end
    end
  end

  // Access FSM with registered controller-side and requester-side outputs.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= StIdle;
      ctl_req_q   <= 1'b0;
      ctl_wr_q    <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      ctl_be_q    <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      acked_q     <= '0;
      busy_q      <= 1'b0;
      grant_q     <= 2'd3;
      rr_q        <= 1'b0;
      wait_q      <= '0;
    end else begin
      ack_q   <= '0;
      acked_q <= '0;
      wait_q  <= wait_d;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            ctl_wr_q    <= wr[pick_id];
            ctl_addr_q  <= addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ctl_wdata_q <= wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            ctl_be_q    <= be[pick_idx*2 +: 2];
            grant_q     <= pick_id;
            ctl_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (ctl_ack) begin
            ctl_req_q <= 1'b0;
            if (ctl_wr_q) begin
              ack_q   <= 3'b001 << grant_q;
              state_q <= StDone;
            end else begin
              state_q <= StWaitData;
            end
          end
        end
        StWaitData: begin
          if (ctl_rvalid) begin
            rdata_q <= ctl_rdata;
            ack_q   <= 3'b001 << grant_q;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Mask the just-served port for one IDLE cycle so a lingering req is not re-granted.
          acked_q <= 3'b001 << grant_q;
          if (grant_q == 2'd1) begin
            rr_q <= 1'b1;
          end else if (grant_q == 2'd2) begin
            rr_q <= 1'b0;
          end
          grant_q <= 2'd3;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign ctl_req   = ctl_req_q;
  assign ctl_wr    = ctl_wr_q;
  assign ctl_addr  = ctl_addr_q;
  assign ctl_wdata = ctl_wdata_q;
  assign ctl_be    = ctl_be_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with hand-computed expectations.
module tb_sdram_port_arbiter;
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 8;

  logic              clk = 1'b0;
  logic              reset_in;
  logic [2:0]        req, wr;
  logic [3*AW-1:0]   addr;
  logic [3*DW-1:0]   wdata;
  logic [5:0]        be;
  logic [2:0]        ack;
  logic [DW-1:0]     rdata;
  logic              ctl_req, ctl_wr;
  logic [AW-1:0]     ctl_addr;
  logic [DW-1:0]     ctl_wdata;
  logic [1:0]        ctl_be;
  logic              ctl_ack, ctl_rvalid;
  logic [DW-1:0]     ctl_rdata;
  logic              busy;
  logic [1:0]        grant_id;

  logic              auto_ack, ack_force;
  logic [2:0]        auto_drop;
  int                n_tests = 0;
  int                n_fail = 0;
  int                ack_log[$];

  // Controller model: accepts immediately when auto_ack, or on a forced pulse.
  assign ctl_ack = ack_force | (auto_ack & ctl_req);

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .ack       (ack),
    .rdata     (rdata),
    .ctl_req   (ctl_req),
    .ctl_wr    (ctl_wr),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_be    (ctl_be),
    .ctl_ack   (ctl_ack),
    .ctl_rvalid(ctl_rvalid),
    .ctl_rdata (ctl_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, log acks and model requester drop.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ack != 3'b000) begin
      if (ack == 3'b001)      ack_log.push_back(0);
      else if (ack == 3'b010) ack_log.push_back(1);
      else if (ack == 3'b100) ack_log.push_back(2);
      else                    ack_log.push_back(9);
    end
    for (int n = 0; n < 3; n++) begin
      if (auto_drop[n] && ack[n]) req[n] = 1'b0;
    end
  endtask

  task automatic set_port(input int n, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] b);
    wr[n]             = w;
    addr[n*AW +: AW]  = a;
    wdata[n*DW +: DW] = d;
    be[n*2 +: 2]      = b;
  endtask

  initial begin
    reset_in   = 1'b1;
    req        = '0;
    wr         = '0;
    addr       = '0;
    wdata      = '0;
    be         = '0;
    ctl_rvalid = 1'b0;
    ctl_rdata  = '0;
    auto_ack   = 1'b0;
    ack_force  = 1'b0;
    auto_drop  = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl_req", 32'(ctl_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h3);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    reset_in = 1'b0;
    tick();

    // 1: single p1 write, immediate controller accept
    auto_ack = 1'b1;
    set_port(1, 1'b1, 25'h000123, 16'hA5A5, 2'b11);
    req[1] = 1'b1;
    tick();
    check("t1_ctl_req", 32'(ctl_req), 32'h1);
    check("t1_grant", 32'(grant_id), 32'h1);
    check("t1_addr", 32'(ctl_addr), 32'h123);
    check("t1_wdata", 32'(ctl_wdata), 32'hA5A5);
    check("t1_be", 32'(ctl_be), 32'h3);
    check("t1_wr", 32'(ctl_wr), 32'h1);
    check("t1_ack_early", 32'(ack), 32'h0);
    tick();
    check("t1_ack", 32'(ack), 32'h2);
    check("t1_req_low", 32'(ctl_req), 32'h0);
    tick();
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_idle_grant", 32'(grant_id), 32'h3);

    // 2: p2 read, rvalid 4 cycles after ctl_ack
    set_port(2, 1'b0, 25'h1FFFFFF, 16'h0000, 2'b11);
    req[2] = 1'b1;
    tick();
    check("t2_grant", 32'(grant_id), 32'h2);
    check("t2_addr", 32'(ctl_addr), 32'h1FFFFFF);
    check("t2_wr", 32'(ctl_wr), 32'h0);
    tick();
    check("t2_wait_busy", 32'(busy), 32'h1);
    check("t2_wait_req", 32'(ctl_req), 32'h0);
    tick();
    tick();
    tick();
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'h5A3C;
    check("t2_no_ack_yet", 32'(ack), 32'h0);
    tick();
    ctl_rvalid = 1'b0;
    ctl_rdata  = 16'h0000;
    check("t2_ack", 32'(ack), 32'h4);
    check("t2_rdata", 32'(rdata), 32'h5A3C);
    tick();
    check("t2_rdata_held", 32'(rdata), 32'h5A3C);
    check("t2_idle", 32'(busy), 32'h0);

    // 3: p1 and p2 held continuously -> alternate grants
    auto_drop = 3'b001;
    set_port(1, 1'b1, 25'h10, 16'h1111, 2'b01);
    set_port(2, 1'b1, 25'h20, 16'h2222, 2'b10);
    ack_log.delete();
    req[1] = 1'b1;
    req[2] = 1'b1;
    repeat (12) tick();
    req[1] = 1'b0;
    req[2] = 1'b0;
    check("t3_nacks", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() >= 4) begin
      check("t3_g0", 32'(ack_log[0]), 32'd1);
      check("t3_g1", 32'(ack_log[1]), 32'd2);
      check("t3_g2", 32'(ack_log[2]), 32'd1);
      check("t3_g3", 32'(ack_log[3]), 32'd2);
    end
    tick();
    check("t3_idle", 32'(busy), 32'h0);

    // 4: starvation promotion of p1 over p0
    auto_drop = 3'b111;
    auto_ack  = 1'b0;
    set_port(0, 1'b1, 25'h30, 16'h3333, 2'b11);
    set_port(2, 1'b1, 25'h40, 16'h4444, 2'b11);
    req[2] = 1'b1;
    tick();
    check("t4_grant_p2", 32'(grant_id), 32'h2);
    req[1] = 1'b1;
    repeat (10) tick();
    req[0] = 1'b1;
    tick();
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    check("t4_ack_p2", 32'(ack), 32'h4);
    auto_ack = 1'b1;
    tick();
    tick();
    check("t4_promoted_p1", 32'(grant_id), 32'h1);
    tick();
    check("t4_ack_p1", 32'(ack), 32'h2);
    tick();
    tick();
    check("t4_p0_resumes", 32'(grant_id), 32'h0);
    tick();
    check("t4_ack_p0", 32'(ack), 32'h1);
    tick();

    // 5: reset during WAIT_DATA, then clean restart with rr back on p1
    set_port(1, 1'b0, 25'h50, 16'h0000, 2'b11);
    req[1] = 1'b1;
    tick();
    tick();
    check("t5_in_wait", 32'(busy), 32'h1);
    auto_ack   = 1'b0;
    reset_in   = 1'b1;
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'hBEEF;
    #1;
    check("t5_rst_req", 32'(ctl_req), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_grant", 32'(grant_id), 32'h3);
    check("t5_rst_rdata", 32'(rdata), 32'h0);
    tick();
    check("t5_rst_noack", 32'(ack), 32'h0);
    reset_in   = 1'b0;
    ctl_rvalid = 1'b0;
    ctl_rdata  = 16'h0000;
    auto_ack   = 1'b1;
    set_port(1, 1'b1, 25'h60, 16'h6666, 2'b11);
    set_port(2, 1'b1, 25'h70, 16'h7777, 2'b11);
    req[1] = 1'b1;
    req[2] = 1'b1;
    tick();
    check("t5_restart_grant", 32'(grant_id), 32'h1);
    tick();
    check("t5_restart_ack", 32'(ack), 32'h2);
    repeat (4) tick();
    check("t5_idle", 32'(busy), 32'h0);

    // 6: req held one cycle past ack, stray ctl_ack/ctl_rvalid in IDLE
    auto_drop = 3'b000;
    ack_log.delete();
    set_port(0, 1'b1, 25'h80, 16'h8888, 2'b11);
    req[0] = 1'b1;
    tick();
    tick();
    check("t6_ack", 32'(ack), 32'h1);
    tick();
    req[0] = 1'b0;
    tick();
    check("t6_no_regrant", 32'(busy), 32'h0);
    check("t6_grant_idle", 32'(grant_id), 32'h3);
    check("t6_one_ack", 32'(ack_log.size()), 32'd1);
    auto_ack   = 1'b0;
    ack_force  = 1'b1;
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'hFFFF;
    tick();
    ack_force  = 1'b0;
    ctl_rvalid = 1'b0;
    tick();
    check("t6_stray_busy", 32'(busy), 32'h0);
    check("t6_stray_ack", 32'(ack), 32'h0);
    check("t6_stray_req", 32'(ctl_req), 32'h0);
    check("t6_stray_rdata", 32'(rdata), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
